// File: rtl/code_lock_pkg.sv
// Shared types and constants for the 1-4-6-9 code lock controller.
package code_lock_pkg;

  localparam int unsigned SEQ_W   = 2;
  localparam int unsigned DIGIT_W = 4;

  typedef logic [SEQ_W-1:0] seq_state_t;

  localparam seq_state_t S0 = 2'b00;
  localparam seq_state_t S1 = 2'b01;
  localparam seq_state_t S2 = 2'b10;
  localparam seq_state_t S3 = 2'b11;

  typedef enum logic [1:0] {
    LOCKED  = 2'b00,
    OPEN    = 2'b01,
    LOCKOUT = 2'b10
  } lock_mode_t;

  localparam logic [DIGIT_W-1:0] DIGIT_1 = 4'd1;
  localparam logic [DIGIT_W-1:0] DIGIT_4 = 4'd4;
  localparam logic [DIGIT_W-1:0] DIGIT_6 = 4'd6;
  localparam logic [DIGIT_W-1:0] DIGIT_9 = 4'd9;

endpackage

// File: rtl/code_lock_ctrl_seq_next_state.sv
// Combinational next-state function of the 1-4-6-9 sequence detector.
module seq_next_state
  import code_lock_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_i,
  input  seq_state_t         state_i,
  output seq_state_t         next_o,
  output logic               code_ok_o,
  output logic               abort_o
);

  always_comb begin
    next_o    = S0;
    code_ok_o = 1'b0;
    if (digit_i == DIGIT_1) begin
      next_o = S1;
    end else if ((digit_i == DIGIT_4) && (state_i == S1)) begin
      next_o = S2;
    end else if ((digit_i == DIGIT_6) && (state_i == S2)) begin
      next_o = S3;
    end else if ((digit_i == DIGIT_9) && (state_i == S3)) begin
      code_ok_o = 1'b1;
    end
    // Falling back to S0 from a partial sequence without the full code.
    abort_o = (state_i != S0) && (next_o == S0) && !code_ok_o;
  end

endmodule

// File: rtl/code_lock_ctrl.sv
// Code lock top: detector state, LOCKED/OPEN/LOCKOUT mode, fail counter, hold timer.
// Optional partial-sequence idle timeout enabled by defining CODE_LOCK_TIMEOUT_EN.
module code_lock_ctrl
  import code_lock_pkg::*;
#(
  parameter int unsigned MAX_FAILS      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 8,
`ifdef CODE_LOCK_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 32,
`endif
  parameter int unsigned LOCKOUT_CYCLES = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [DIGIT_W-1:0]               data_i,
  input  logic                             valid_i,
  output logic                             ready_o,
  output logic                             unlock_o,
  output logic                             lockout_o,
  output logic [SEQ_W-1:0]                 SeqState_o,
  output logic [$clog2(MAX_FAILS+1)-1:0]   FailCnt_o
);

  localparam int unsigned FAIL_W  = $clog2(MAX_FAILS + 1);
  localparam int unsigned TMR_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES
                                                                     : LOCKOUT_CYCLES;
  localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

  lock_mode_t        mode_q, mode_d;
  seq_state_t        seq_q, seq_d;
  logic [FAIL_W-1:0] fail_q, fail_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;

  seq_state_t        nxt_seq;
  logic              code_ok;
  logic              abort;
  logic              accept_c;

  seq_next_state u_seq_next_state (
    .digit_i   (data_i),
    .state_i   (seq_q),
    .next_o    (nxt_seq),
    .code_ok_o (code_ok),
    .abort_o   (abort)
  );

`ifdef CODE_LOCK_TIMEOUT_EN
  localparam int unsigned IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [IDLE_W-1:0] idle_q, idle_d;
`endif

  always_comb begin
    mode_d   = mode_q;
    seq_d    = seq_q;
    fail_d   = fail_q;
    tmr_d    = tmr_q;
    accept_c = valid_i && (mode_q == LOCKED);
    unique case (mode_q)
      LOCKED: begin
        if (accept_c) begin
          seq_d = nxt_seq;
          if (code_ok) begin
            mode_d = OPEN;
            seq_d  = S0;
            fail_d = '0;
            tmr_d  = TMR_W'(UNLOCK_CYCLES - 1);
          end else if (abort) begin
            if (fail_q == FAIL_W'(MAX_FAILS - 1)) begin
              mode_d = LOCKOUT;
              fail_d = FAIL_W'(MAX_FAILS);
              tmr_d  = TMR_W'(LOCKOUT_CYCLES - 1);
            end else begin
              fail_d = fail_q + FAIL_W'(1);
            end
          end
        end
      end
      OPEN: begin
        if (tmr_q == '0) begin
          mode_d = LOCKED;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      LOCKOUT: begin
        if (tmr_q == '0) begin
          mode_d = LOCKED;
          fail_d = '0;
          seq_d  = S0;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: mode_d = LOCKED;
    endcase

`ifdef CODE_LOCK_TIMEOUT_EN
    // Abandon a stale partial sequence; an accepted digit always wins.
    idle_d = idle_q;
    if ((mode_q != LOCKED) || (seq_q == S0) || accept_c) begin
      idle_d = '0;
    end else if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
      idle_d = '0;
      seq_d  = S0;
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mode_q <= LOCKED;
      seq_q  <= S0;
      fail_q <= '0;
      tmr_q  <= '0;
`ifdef CODE_LOCK_TIMEOUT_EN
      idle_q <= '0;
`endif
    end else begin
      mode_q <= mode_d;
      seq_q  <= seq_d;
      fail_q <= fail_d;
      tmr_q  <= tmr_d;
`ifdef CODE_LOCK_TIMEOUT_EN
      idle_q <= idle_d;
`endif
    end
  end

  assign ready_o    = (mode_q == LOCKED);
  assign unlock_o   = (mode_q == OPEN);
  assign lockout_o  = (mode_q == LOCKOUT);
  assign SeqState_o = seq_q;
  assign FailCnt_o  = fail_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Scoreboard bench for code_lock_ctrl: driver queues hand-computed status, monitor compares each cycle.
module tb_code_lock_ctrl;

  typedef struct packed {
    logic       ready;
    logic       unlock;
    logic       lockout;
    logic [1:0] seq;
    logic [1:0] fail;
  } obs_t;

  localparam logic [1:0] M_LK = 2'd0;
  localparam logic [1:0] M_OP = 2'd1;
  localparam logic [1:0] M_LO = 2'd2;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic [3:0] data_i = 4'd0;
  logic       valid_i = 1'b0;
  logic       ready_o, unlock_o, lockout_o;
  logic [1:0] SeqState_o;
  logic [1:0] FailCnt_o;

  obs_t       exp_q[$];
  string      name_q[$];
  int         n_checks = 0;
  int         n_pass   = 0;

  code_lock_ctrl dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .data_i     (data_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .unlock_o   (unlock_o),
    .lockout_o  (lockout_o),
    .SeqState_o (SeqState_o),
    .FailCnt_o  (FailCnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Drive one cycle of stimulus and queue the status expected after the next edge.
  task automatic step(input string nm, input logic rst, input logic v, input logic [3:0] d,
                      input logic [1:0] mode, input logic [1:0] seq, input logic [1:0] fail);
    obs_t e;
    @(negedge clk_i);
    rst_i   = rst;
    valid_i = v;
    data_i  = d;
    e.ready   = (mode == M_LK);
    e.unlock  = (mode == M_OP);
    e.lockout = (mode == M_LO);
    e.seq     = seq;
    e.fail    = fail;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // Monitor: status is presented every cycle, compared one step after the edge.
  initial begin
    obs_t  got, e;
    string nm;
    forever begin
      @(posedge clk_i);
      #1;
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        got = '{ready: ready_o, unlock: unlock_o, lockout: lockout_o,
                seq: SeqState_o, fail: FailCnt_o};
        n_checks++;
        if (got === e) n_pass++;
        else $display("FAIL %s: got rdy=%b unl=%b lko=%b seq=%b fail=%0d, want rdy=%b unl=%b lko=%b seq=%b fail=%0d",
                      nm, got.ready, got.unlock, got.lockout, got.seq, got.fail,
                      e.ready, e.unlock, e.lockout, e.seq, e.fail);
      end
    end
  end

  initial begin
    int wait_cycles;
    step("reset", 1, 0, 4'd0, M_LK, 2'b00, 2'd0);

    // Correct code, then an 8-cycle open window that ignores strobes.
    step("code_1", 0, 1, 4'd1, M_LK, 2'b01, 2'd0);
    step("code_4", 0, 1, 4'd4, M_LK, 2'b10, 2'd0);
    step("code_6", 0, 1, 4'd6, M_LK, 2'b11, 2'd0);
    step("code_9", 0, 1, 4'd9, M_OP, 2'b00, 2'd0);
    for (int i = 0; i < 7; i++) step("open_hold", 0, (i < 3), 4'd1, M_OP, 2'b00, 2'd0);
    step("open_exit", 0, 0, 4'd0, M_LK, 2'b00, 2'd0);

    // Abort after 1-4, then wrong digits in S0 do not count.
    step("ab_1", 0, 1, 4'd1, M_LK, 2'b01, 2'd0);
    step("ab_4", 0, 1, 4'd4, M_LK, 2'b10, 2'd0);
    step("ab_5", 0, 1, 4'd5, M_LK, 2'b00, 2'd1);
    step("s0_3a", 0, 1, 4'd3, M_LK, 2'b00, 2'd1);
    step("s0_3b", 0, 1, 4'd3, M_LK, 2'b00, 2'd1);
    step("idle", 0, 0, 4'd9, M_LK, 2'b00, 2'd1);

    // Restart with 1 mid-sequence is not a failure; unlock clears the count.
    step("rs_1", 0, 1, 4'd1, M_LK, 2'b01, 2'd1);
    step("rs_4", 0, 1, 4'd4, M_LK, 2'b10, 2'd1);
    step("rs_1b", 0, 1, 4'd1, M_LK, 2'b01, 2'd1);
    step("rs_4b", 0, 1, 4'd4, M_LK, 2'b10, 2'd1);
    step("rs_6", 0, 1, 4'd6, M_LK, 2'b11, 2'd1);
    step("rs_9", 0, 1, 4'd9, M_OP, 2'b00, 2'd0);
    for (int i = 0; i < 7; i++) step("rs_open", 0, 0, 4'd0, M_OP, 2'b00, 2'd0);
    step("rs_exit", 0, 0, 4'd0, M_LK, 2'b00, 2'd0);

    // Three aborts -> 16-cycle lockout ignoring the full code.
    step("lo_1a", 0, 1, 4'd1, M_LK, 2'b01, 2'd0);
    step("lo_7a", 0, 1, 4'd7, M_LK, 2'b00, 2'd1);
    step("lo_1b", 0, 1, 4'd1, M_LK, 2'b01, 2'd1);
    step("lo_7b", 0, 1, 4'd7, M_LK, 2'b00, 2'd2);
    step("lo_1c", 0, 1, 4'd1, M_LK, 2'b01, 2'd2);
    step("lo_7c", 0, 1, 4'd7, M_LO, 2'b00, 2'd3);
    step("lo_ign1", 0, 1, 4'd1, M_LO, 2'b00, 2'd3);
    step("lo_ign4", 0, 1, 4'd4, M_LO, 2'b00, 2'd3);
    step("lo_ign6", 0, 1, 4'd6, M_LO, 2'b00, 2'd3);
    step("lo_ign9", 0, 1, 4'd9, M_LO, 2'b00, 2'd3);
    for (int i = 0; i < 11; i++) step("lo_hold", 0, 0, 4'd0, M_LO, 2'b00, 2'd3);
    step("lo_exit", 0, 0, 4'd0, M_LK, 2'b00, 2'd0);

    // Wrong-order digits from partial states.
    step("wo_1", 0, 1, 4'd1, M_LK, 2'b01, 2'd0);
    step("wo_9", 0, 1, 4'd9, M_LK, 2'b00, 2'd1);
    step("wo_6", 0, 1, 4'd6, M_LK, 2'b00, 2'd1);

    // Reset during the 4th OPEN cycle.
    step("ro_1", 0, 1, 4'd1, M_LK, 2'b01, 2'd1);
    step("ro_4", 0, 1, 4'd4, M_LK, 2'b10, 2'd1);
    step("ro_6", 0, 1, 4'd6, M_LK, 2'b11, 2'd1);
    step("ro_9", 0, 1, 4'd9, M_OP, 2'b00, 2'd0);
    for (int i = 0; i < 3; i++) step("ro_open", 0, 0, 4'd0, M_OP, 2'b00, 2'd0);
    step("ro_rst", 1, 0, 4'd0, M_LK, 2'b00, 2'd0);

    // Reset in the middle of a lockout.
    for (int i = 0; i < 3; i++) begin
      step("rl_1", 0, 1, 4'd1, M_LK, 2'b01, 2'(i));
      step("rl_2", 0, 1, 4'd2, (i == 2) ? M_LO : M_LK, 2'b00, 2'(i + 1));
    end
    for (int i = 0; i < 5; i++) step("rl_hold", 0, 0, 4'd0, M_LO, 2'b00, 2'd3);
    step("rl_rst", 1, 1, 4'd1, M_LK, 2'b00, 2'd0);
    step("post_1", 0, 1, 4'd1, M_LK, 2'b01, 2'd0);

`ifdef CODE_LOCK_TIMEOUT_EN
    // Partial sequence expires after 32 idle cycles; a digit on cycle 32 wins.
    for (int i = 0; i < 31; i++) step("to_idle", 0, 0, 4'd0, M_LK, 2'b01, 2'd0);
    step("to_expire", 0, 0, 4'd0, M_LK, 2'b00, 2'd0);
    step("to_1", 0, 1, 4'd1, M_LK, 2'b01, 2'd0);
    for (int i = 0; i < 31; i++) step("to_idle2", 0, 0, 4'd0, M_LK, 2'b01, 2'd0);
    step("to_win4", 0, 1, 4'd4, M_LK, 2'b10, 2'd0);
`endif

    @(negedge clk_i);
    valid_i = 1'b0;
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk_i);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
